// File: rtl/wb_cpu_master.sv
// Wishbone initiator: one CPU request -> one single-cycle stb transfer.
// Optional ack timeout enabled by defining WB_TIMEOUT_EN.
module wb_cpu_master #(
  parameter int WB_DATA_WIDTH  = 8,
  parameter int WB_ADDR_WIDTH  = 7,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [WB_ADDR_WIDTH-1:0] cpu_adr,
  input  logic [WB_DATA_WIDTH-1:0] cpu_wdat,
  output logic [WB_DATA_WIDTH-1:0] cpu_rdat,
  output logic                     cpu_done,
  output logic                     cpu_rdy,
  input  logic                     stall_i,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  output logic                     err_o
);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT
  } state_t;

  state_t                     state;
  state_t                     state_n;
  logic                       stb_n;
  logic                       we_n;
  logic [WB_ADDR_WIDTH-1:0]   adr_n;
  logic [WB_DATA_WIDTH-1:0]   dat_n;
  logic [WB_DATA_WIDTH-1:0]   rdat_n;
  logic                       done_n;
  logic                       err_n;
  logic                       to_hit;

`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  // Expiry only counts when no ack arrives on the same edge.
  assign to_hit = !ack_i && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Acceptance is gated by idle state and the responder stall.
  assign cpu_rdy = (state == IDLE) && !stall_i;

  // Next-state and registered-output computation.
  always_comb begin
    state_n = state;
    stb_n   = 1'b0;
    we_n    = we_o;
    adr_n   = adr_o;
    dat_n   = dat_o;
    rdat_n  = cpu_rdat;
    done_n  = 1'b0;
    err_n   = err_o;
`ifdef WB_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (cpu_req && cpu_rdy) begin
          state_n = STROBE;
          stb_n   = 1'b1;
          we_n    = cpu_we;
          adr_n   = cpu_adr;
          dat_n   = cpu_wdat;
`ifdef WB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      STROBE, WAIT: begin
        if (ack_i) begin
          state_n = IDLE;
          done_n  = 1'b1;
          if (!we_o) rdat_n = dat_i;
        end else if (to_hit) begin
          state_n = IDLE;
          done_n  = 1'b1;
          err_n   = 1'b1;
          if (!we_o) rdat_n = '1;
        end else begin
          state_n = WAIT;
`ifdef WB_TIMEOUT_EN
          cnt_n   = cnt + 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      stb_o    <= 1'b0;
      we_o     <= 1'b0;
      adr_o    <= '0;
      dat_o    <= '0;
      cpu_rdat <= '0;
      cpu_done <= 1'b0;
      err_o    <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_n;
      stb_o    <= stb_n;
      we_o     <= we_n;
      adr_o    <= adr_n;
      dat_o    <= dat_n;
      cpu_rdat <= rdat_n;
      cpu_done <= done_n;
      err_o    <= err_n;
`ifdef WB_TIMEOUT_EN
      cnt      <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_wb_cpu_master.sv
// Bench for wb_cpu_master: bench-side responder with memory model,
// directed cases plus randomized transfers with random ack delay.
module tb_wb_cpu_master;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       cpu_req;
  logic       cpu_we;
  logic [6:0] cpu_adr;
  logic [7:0] cpu_wdat;
  logic [7:0] cpu_rdat;
  logic       cpu_done;
  logic       cpu_rdy;
  logic       stall_i;
  logic       stb_o;
  logic       we_o;
  logic [6:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack_i;
  logic       err_o;

  wb_cpu_master dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_adr  (cpu_adr),
    .cpu_wdat (cpu_wdat),
    .cpu_rdat (cpu_rdat),
    .cpu_done (cpu_done),
    .cpu_rdy  (cpu_rdy),
    .stall_i  (stall_i),
    .stb_o    (stb_o),
    .we_o     (we_o),
    .adr_o    (adr_o),
    .dat_o    (dat_o),
    .dat_i    (dat_i),
    .ack_i    (ack_i),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mem [128];
  logic [7:0] exp_rdat;
  int cyc = 0;
  int stb_cyc = 0;
  int last_gap = 0;
  int n_stb = 0;
  int n_done = 0;
  int stb_pulses = 0;
  int done_pulses = 0;
  int stb_long = 0;
  int done_long = 0;
  logic prev_stb = 1'b0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (stb_o && !prev_stb) stb_pulses++;
    if (stb_o && prev_stb) stb_long++;
    if (cpu_done && !prev_done) done_pulses++;
    if (cpu_done && prev_done) done_long++;
    prev_stb = stb_o;
    prev_done = cpu_done;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One transfer; ack arrives dly cycles after the stb cycle.
  // Starts and ends at a negedge; ends in the cpu_done cycle.
  task automatic do_xfer(input logic we, input logic [6:0] a,
                         input logic [7:0] wd, input int dly,
                         input bit smid);
    check("rdy_idle", cpu_rdy, 1);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_adr = a;
    cpu_wdat = wd;
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_we = 1'($urandom);
    cpu_adr = 7'($urandom);
    cpu_wdat = 8'($urandom);
    n_stb++;
    last_gap = cyc - stb_cyc;
    stb_cyc = cyc;
    check("stb_hi", stb_o, 1);
    check("we_o", we_o, we);
    check("adr_o", adr_o, a);
    check("dat_o", dat_o, wd);
    check("rdy_busy", cpu_rdy, 0);
    check("done_early", cpu_done, 0);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (smid && i == 0) stall_i = 1'b1;
      check("stb_wait", stb_o, 0);
      check("done_wait", cpu_done, 0);
      check("adr_hold", adr_o, a);
    end
    ack_i = 1'b1;
    dat_i = we ? 8'($urandom) : mem[a];
    @(negedge clk);
    ack_i = 1'b0;
    dat_i = 8'($urandom);
    n_done++;
    if (we) mem[a] = wd;
    else exp_rdat = mem[a];
    check("done", cpu_done, 1);
    check("rdat", cpu_rdat, exp_rdat);
    check("stb_done", stb_o, 0);
    check("rdy_done", cpu_rdy, !stall_i);
    check("dat_hold", dat_o, wd);
    if (smid) begin
      @(negedge clk);
      check("rdy_stall", cpu_rdy, 0);
      check("done_1cyc", cpu_done, 0);
      stall_i = 1'b0;
      #1;
      check("rdy_unstall", cpu_rdy, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] wv;
    int t0;
    rst_i = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_adr = '0;
    cpu_wdat = '0;
    stall_i = 1'b0;
    dat_i = '0;
    ack_i = 1'b0;
    exp_rdat = '0;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[12] = 8'h80;
    repeat (3) @(negedge clk);
    check("rst_stb", stb_o, 0);
    check("rst_we", we_o, 0);
    check("rst_adr", adr_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_rdat", cpu_rdat, 0);
    check("rst_done", cpu_done, 0);
    check("rst_err", err_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", cpu_rdy, 1);

    // write then read with registered-ack responder
    do_xfer(1'b1, 7'h09, 8'h46, 1, 0);
    check("w_lat", cyc - stb_cyc, 2);
    @(negedge clk);
    check("done_pulse", cpu_done, 0);
    do_xfer(1'b0, 7'h0C, 8'h00, 1, 0);
    check("rd_80", cpu_rdat, 8'h80);
    do_xfer(1'b1, 7'h0D, 8'h33, 0, 0);
    check("rd_keep", cpu_rdat, 8'h80);

    // stall after a write
    do_xfer(1'b1, 7'h02, 8'h5A, 1, 0);
    stall_i = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      check("stall_rdy", cpu_rdy, 0);
      check("stall_stb", stb_o, 0);
      cpu_req = (i % 3 == 0);
      cpu_we = 1'b1;
      @(negedge clk);
    end
    cpu_req = 1'b0;
    check("stall_stb_end", stb_o, 0);
    stall_i = 1'b0;
    #1;
    check("stall_release", cpu_rdy, 1);
    @(negedge clk);

    // back-to-back writes issued in each cpu_done cycle
    for (int k = 0; k < 4; k++) begin
      wv = 8'($urandom);
      do_xfer(1'b1, 7'(k + 32), wv, 1, 0);
      if (k > 0) check("b2b_gap", last_gap, 3);
    end

    // stall raised during WAIT does not abort
    do_xfer(1'b0, 7'h0C, 8'h00, 3, 1);

    // reset mid-transfer, late ack ignored
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_adr = 7'h05;
    @(negedge clk);
    cpu_req = 1'b0;
    n_stb++;
    check("rm_stb", stb_o, 1);
    @(negedge clk);
    check("rm_wait", stb_o, 0);
    rst_i = 1'b1;
    @(negedge clk);
    check("rm_stb_rst", stb_o, 0);
    check("rm_done_rst", cpu_done, 0);
    check("rm_rdat", cpu_rdat, 0);
    rst_i = 1'b0;
    ack_i = 1'b1;
    dat_i = 8'hA5;
    #1;
    check("rm_rdy", cpu_rdy, 1);
    @(negedge clk);
    ack_i = 1'b0;
    exp_rdat = '0;
    check("rm_late_done", cpu_done, 0);
    check("rm_late_rdat", cpu_rdat, 0);
    check("rm_late_stb", stb_o, 0);

`ifdef WB_TIMEOUT_EN
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_adr = 7'h07;
    @(negedge clk);
    cpu_req = 1'b0;
    n_stb++;
    n_done++;
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_done) break;
    end
    check("to_lat", cyc - t0, 15);
    check("to_rdat", cpu_rdat, 8'hFF);
    check("to_err", err_o, 1);
    repeat (3) @(negedge clk);
    check("to_err_stk", err_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("to_err_clr", err_o, 0);
    exp_rdat = '0;
    @(negedge clk);
`else
    t0 = 0;
    do_xfer(1'b0, 7'h07, 8'h00, 30, 0);
    check("no_err", err_o, 0);
    check("no_to_lat", cyc - stb_cyc, t0 + 31);
    @(negedge clk);
`endif

    // randomized transfers with stray idle acks
    for (int n = 0; n < 40; n++) begin
      int gap;
      int dly;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        ack_i = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        ack_i = 1'b0;
        check("idle_ack", cpu_done, 0);
      end
      dly = $urandom_range(0, 4);
      do_xfer(1'($urandom), 7'($urandom), 8'($urandom), dly,
              (dly > 0) && ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    check("stb_count", stb_pulses, n_stb);
    check("done_count", done_pulses, n_done);
    check("stb_long", stb_long, 0);
    check("done_long", done_long, 0);
    check("err_final", err_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
